// File: rtl/irda_mode_switch_ctrl_pkg.sv
// Shared mode codes, sequencer state encodings and the mode-bit encoder
// used by the IrDA mode switch controller.
package irda_mode_switch_ctrl_pkg;

  localparam int IRDA_FIFO_POINTER_W = 4;

  localparam logic [1:0] IRDA_MODE_SIR  = 2'b00;
  localparam logic [1:0] IRDA_MODE_MIRH = 2'b01;
  localparam logic [1:0] IRDA_MODE_MIRF = 2'b10;
  localparam logic [1:0] IRDA_MODE_FIR  = 2'b11;

  localparam logic [2:0] IRDA_MSW_IDLE   = 3'd0;
  localparam logic [2:0] IRDA_MSW_HOLD   = 3'd1;
  localparam logic [2:0] IRDA_MSW_FLUSH  = 3'd2;
  localparam logic [2:0] IRDA_MSW_RELOAD = 3'd3;
  localparam logic [2:0] IRDA_MSW_SETTLE = 3'd4;
  localparam logic [2:0] IRDA_MSW_DONE   = 3'd5;

  typedef struct packed {
    logic fast;
    logic mir;
    logic half;
    logic fir;
  } mode_bits_t;

  // One place that defines how a 2-bit mode code maps onto the consumer enables.
  function automatic mode_bits_t mode_encode(input logic [1:0] mode);
    mode_bits_t bits;
    bits = '0;
    case (mode)
      IRDA_MODE_MIRH: bits = '{fast: 1'b1, mir: 1'b1, half: 1'b1, fir: 1'b0};
      IRDA_MODE_MIRF: bits = '{fast: 1'b1, mir: 1'b1, half: 1'b0, fir: 1'b0};
      IRDA_MODE_FIR:  bits = '{fast: 1'b1, mir: 1'b0, half: 1'b0, fir: 1'b1};
      default:        bits = '0;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/irda_mode_switch_ctrl_counter.sv
// Shared cycle counter for the mode switch sequencer: synchronous clear,
// counts while enabled and saturates at the terminal value (limit-1).
module irda_msw_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             terminal
);

  logic [CNT_W-1:0] count;

  assign terminal = (count == (limit - CNT_W'(1)));

  // Holding at the terminal value keeps the count from ever wrapping inside a state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/irda_mode_switch_ctrl.sv
// Sequences SIR/MIR/FIR mode changes: hold TX, drain, flush both FIFOs,
// apply the new mode bits, reload the fast enable generator and let it settle.
module irda_mode_switch_ctrl
  import irda_mode_switch_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 4096,
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int          CNT_W         = 16,
  parameter int          FIFO_PTR_W    = IRDA_FIFO_POINTER_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_i,
  input  logic [1:0]        req_mode_i,
  input  logic              abort_i,
  input  logic              tx_busy_i,
  input  logic              rx_busy_i,
  input  logic [FIFO_PTR_W:0] txfifo_count_i,
  output logic              fast_mode_o,
  output logic              mir_mode_o,
  output logic              mir_half_o,
  output logic              fir_mode_o,
  output logic              tx_hold_o,
  output logic              txfifo_clear_o,
  output logic              rxfifo_clear_o,
  output logic              en_reload_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              reject_o
);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  mode_bits_t       mode_q;
  mode_bits_t       target_bits;
  mode_bits_t       req_bits;
  logic             abort_lat;
  logic             timeout_flag;
  logic             timeout_nx;
  logic             drain_idle;
  logic             start;
  logic             same_hit;
  logic             cnt_clear;
  logic             cnt_enable;
  logic             cnt_terminal;
  logic [CNT_W-1:0] cnt_limit;

  assign req_bits   = mode_encode(req_mode_i);
  assign drain_idle = !tx_busy_i && !rx_busy_i && (txfifo_count_i == '0);
  assign start      = req_i && (state == IRDA_MSW_IDLE) && (req_bits != mode_q);
  assign same_hit   = req_i && (state == IRDA_MSW_IDLE) && (req_bits == mode_q);

  assign cnt_clear  = (state_nx != state);
  assign cnt_enable = (state == IRDA_MSW_HOLD) || (state == IRDA_MSW_FLUSH) ||
                      (state == IRDA_MSW_SETTLE);

  always_comb begin
    cnt_limit = '0;
    case (state)
      IRDA_MSW_HOLD:   cnt_limit = CNT_W'(DRAIN_TIMEOUT);
      IRDA_MSW_FLUSH:  cnt_limit = CNT_W'(FLUSH_CYCLES);
      IRDA_MSW_SETTLE: cnt_limit = CNT_W'(SETTLE_CYCLES);
      default:         cnt_limit = '0;
    endcase
  end

  irda_msw_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .limit    (cnt_limit),
    .terminal (cnt_terminal)
  );

  // A drained path takes priority over the timeout so a late drain is never flagged.
  always_comb begin
    state_nx   = state;
    timeout_nx = timeout_flag;
    case (state)
      IRDA_MSW_IDLE: begin
        if (start) begin
          state_nx   = IRDA_MSW_HOLD;
          timeout_nx = 1'b0;
        end
      end
      IRDA_MSW_HOLD: begin
        if (abort_lat || drain_idle) begin
          state_nx = IRDA_MSW_FLUSH;
        end else if (cnt_terminal) begin
          state_nx   = IRDA_MSW_FLUSH;
          timeout_nx = 1'b1;
        end
      end
      IRDA_MSW_FLUSH: begin
        if (cnt_terminal) state_nx = IRDA_MSW_RELOAD;
      end
      IRDA_MSW_RELOAD: state_nx = IRDA_MSW_SETTLE;
      IRDA_MSW_SETTLE: begin
        if (cnt_terminal) state_nx = IRDA_MSW_DONE;
      end
      IRDA_MSW_DONE:   state_nx = IRDA_MSW_IDLE;
      default:         state_nx = IRDA_MSW_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with the state it describes.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= IRDA_MSW_IDLE;
      mode_q         <= '0;
      target_bits    <= '0;
      abort_lat      <= 1'b0;
      timeout_flag   <= 1'b0;
      tx_hold_o      <= 1'b0;
      busy_o         <= 1'b0;
      txfifo_clear_o <= 1'b0;
      rxfifo_clear_o <= 1'b0;
      en_reload_o    <= 1'b0;
      done_o         <= 1'b0;
      timeout_o      <= 1'b0;
      reject_o       <= 1'b0;
    end else begin
      state        <= state_nx;
      timeout_flag <= timeout_nx;
      if (start) begin
        target_bits <= req_bits;
        abort_lat   <= abort_i;
      end
      if ((state == IRDA_MSW_FLUSH) && (state_nx == IRDA_MSW_RELOAD)) begin
        mode_q <= target_bits;
      end
      tx_hold_o      <= (state_nx != IRDA_MSW_IDLE);
      busy_o         <= (state_nx != IRDA_MSW_IDLE);
      txfifo_clear_o <= (state_nx == IRDA_MSW_FLUSH);
      rxfifo_clear_o <= (state_nx == IRDA_MSW_FLUSH);
      en_reload_o    <= (state_nx == IRDA_MSW_RELOAD);
      done_o         <= (state_nx == IRDA_MSW_DONE) || same_hit;
      timeout_o      <= (state_nx == IRDA_MSW_DONE) && timeout_nx;
      reject_o       <= req_i && (state != IRDA_MSW_IDLE);
    end
  end

  assign fast_mode_o = mode_q.fast;
  assign mir_mode_o  = mode_q.mir;
  assign mir_half_o  = mode_q.half;
  assign fir_mode_o  = mode_q.fir;

endmodule

// File: tb/tb_irda_mode_switch_ctrl.sv
// Directed bench for irda_mode_switch_ctrl: a vector table for the basic
// SIR->FIR switch plus hand sequences for drain, timeout, abort, reject and reset.
module tb_irda_mode_switch_ctrl;
  import irda_mode_switch_ctrl_pkg::*;

  localparam int FW = IRDA_FIFO_POINTER_W + 1;

  // Output vector bit order: fast mir half fir | hold txclr rxclr reload | busy done timeout reject
  localparam logic [11:0] E_ZERO     = 12'b0000_0000_0000;
  localparam logic [11:0] E_HOLD     = 12'b0000_1000_1000;
  localparam logic [11:0] E_FLUSH    = 12'b0000_1110_1000;
  localparam logic [11:0] E_RELOAD_F = 12'b1001_1001_1000;
  localparam logic [11:0] E_SETTLE_F = 12'b1001_1000_1000;
  localparam logic [11:0] E_DONE_F   = 12'b1001_1000_1100;
  localparam logic [11:0] E_IDLE_F   = 12'b1001_0000_0000;
  localparam logic [11:0] E_SAME_F   = 12'b1001_0000_0100;

  typedef struct {
    logic        rst;
    logic        req;
    logic [1:0]  mode;
    logic        abort;
    logic        txb;
    logic [11:0] exp;
    string       name;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [1:0]    req_mode;
  logic          abort;
  logic          tx_busy;
  logic          rx_busy;
  logic [FW-1:0] txcnt;
  wire  [11:0]   obs_a;
  wire  [11:0]   obs_b;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  irda_mode_switch_ctrl dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .req_i          (req),
    .req_mode_i     (req_mode),
    .abort_i        (abort),
    .tx_busy_i      (tx_busy),
    .rx_busy_i      (rx_busy),
    .txfifo_count_i (txcnt),
    .fast_mode_o    (obs_a[11]),
    .mir_mode_o     (obs_a[10]),
    .mir_half_o     (obs_a[9]),
    .fir_mode_o     (obs_a[8]),
    .tx_hold_o      (obs_a[7]),
    .txfifo_clear_o (obs_a[6]),
    .rxfifo_clear_o (obs_a[5]),
    .en_reload_o    (obs_a[4]),
    .busy_o         (obs_a[3]),
    .done_o         (obs_a[2]),
    .timeout_o      (obs_a[1]),
    .reject_o       (obs_a[0])
  );

  irda_mode_switch_ctrl #(
    .DRAIN_TIMEOUT (16)
  ) dut_to (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .req_i          (req),
    .req_mode_i     (req_mode),
    .abort_i        (abort),
    .tx_busy_i      (tx_busy),
    .rx_busy_i      (rx_busy),
    .txfifo_count_i (txcnt),
    .fast_mode_o    (obs_b[11]),
    .mir_mode_o     (obs_b[10]),
    .mir_half_o     (obs_b[9]),
    .fir_mode_o     (obs_b[8]),
    .tx_hold_o      (obs_b[7]),
    .txfifo_clear_o (obs_b[6]),
    .rxfifo_clear_o (obs_b[5]),
    .en_reload_o    (obs_b[4]),
    .busy_o         (obs_b[3]),
    .done_o         (obs_b[2]),
    .timeout_o      (obs_b[1]),
    .reject_o       (obs_b[0])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    req      = v.req;
    req_mode = v.mode;
    abort    = v.abort;
    tx_busy  = v.txb;
    rx_busy  = 1'b0;
    txcnt    = '0;
  endtask

  function automatic void addRow(input logic r, input logic q, input logic [1:0] m,
                                 input logic a, input logic t, input logic [11:0] e,
                                 input string n);
    vec_t v;
    v.rst = r; v.req = q; v.mode = m; v.abort = a; v.txb = t; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic doReset();
    rst = 1'b1; req = 1'b0; req_mode = 2'b00; abort = 1'b0;
    tx_busy = 1'b0; rx_busy = 1'b0; txcnt = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs until done_o of the selected instance, bounded; reports cycles, clears, reloads.
  task automatic waitDone(input int which, output int cycles, output int clears,
                          output int reloads, output logic seen, output logic [11:0] at_done);
    logic [11:0] o;
    seen = 1'b0; cycles = 0; clears = 0; reloads = 0; at_done = '0;
    for (int i = 0; i < 80 && !seen; i++) begin
      tick();
      cycles++;
      o = (which == 0) ? obs_a : obs_b;
      if (o[6]) clears++;
      if (o[4]) reloads++;
      if (o[2]) begin
        seen    = 1'b1;
        at_done = o;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cyc, clr, rel, hold_cnt, n, dn;
    logic        seen;
    logic [11:0] at_done;

    rst = 1'b1; req = 1'b0; req_mode = 2'b00; abort = 1'b0;
    tx_busy = 1'b0; rx_busy = 1'b0; txcnt = '0;

    addRow(1, 0, 2'b00, 0, 0, E_ZERO,     "reset");
    addRow(0, 1, 2'b11, 0, 0, E_HOLD,     "req_fir_hold");
    addRow(0, 0, 2'b00, 0, 0, E_FLUSH,    "flush0");
    addRow(0, 0, 2'b00, 0, 0, E_FLUSH,    "flush1");
    addRow(0, 0, 2'b00, 0, 0, E_RELOAD_F, "reload");
    for (int k = 0; k < 8; k++)
      addRow(0, 0, 2'b00, 0, 0, E_SETTLE_F, $sformatf("settle%0d", k));
    addRow(0, 0, 2'b00, 0, 0, E_DONE_F,   "done");
    addRow(0, 0, 2'b00, 0, 0, E_IDLE_F,   "idle");
    addRow(0, 1, 2'b11, 0, 0, E_SAME_F,   "same_mode_done");
    addRow(0, 0, 2'b00, 0, 0, E_IDLE_F,   "same_mode_idle");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput(vecs[i].name, obs_a, vecs[i].exp);
    end

    // Drain wait: tx busy, then rx busy, then a non-empty TX fifo all keep HOLD.
    doReset();
    tx_busy = 1'b1; req = 1'b1; req_mode = 2'b10;
    tick();
    req = 1'b0;
    checkOutput("t2_hold_enter", obs_a, E_HOLD);
    clr = 0; hold_cnt = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (obs_a[6]) clr++;
      if (obs_a[7]) hold_cnt++;
    end
    tx_busy = 1'b0; rx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_a[6]) clr++;
      if (obs_a[7]) hold_cnt++;
    end
    rx_busy = 1'b0; txcnt = FW'(3);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_a[6]) clr++;
      if (obs_a[7]) hold_cnt++;
    end
    txcnt = '0;
    checkOutput("t2_no_clear_in_hold", clr, 0);
    checkOutput("t2_hold_cycles", hold_cnt, 105);
    waitDone(0, cyc, clr, rel, seen, at_done);
    checkOutput("t2_done_seen", seen, 1);
    checkOutput("t2_done_latency", cyc, 12);
    checkOutput("t2_clear_cycles", clr, 2);
    checkOutput("t2_reload_pulses", rel, 1);
    checkOutput("t2_timeout", at_done[1], 0);
    checkOutput("t2_mode_mirf", at_done[11:8], 4'b1100);

    // Forced flush after the drain timeout on the short-timeout instance.
    doReset();
    tx_busy = 1'b1; req = 1'b1; req_mode = 2'b11;
    tick();
    req = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (obs_b[6]) break;
    end
    checkOutput("t3_hold_len", n, 16);
    waitDone(1, cyc, clr, rel, seen, at_done);
    checkOutput("t3_done_seen", seen, 1);
    checkOutput("t3_done_latency", cyc, 11);
    checkOutput("t3_timeout", at_done[1], 1);
    checkOutput("t3_mode_fir", at_done[11:8], 4'b1001);
    tx_busy = 1'b0;

    // Abort skips the drain even with data in the TX fifo.
    doReset();
    txcnt = FW'(5); abort = 1'b1; req = 1'b1; req_mode = 2'b01;
    tick();
    req = 1'b0; abort = 1'b0;
    checkOutput("t4_hold", obs_a, E_HOLD);
    tick();
    checkOutput("t4_flush_now", obs_a[6:5], 2'b11);
    waitDone(0, cyc, clr, rel, seen, at_done);
    checkOutput("t4_done_seen", seen, 1);
    checkOutput("t4_mode_mirh", at_done[11:8], 4'b1110);
    txcnt = '0;

    // Request during SETTLE is rejected and the running sequence is untouched.
    doReset();
    req = 1'b1; req_mode = 2'b11;
    tick();
    dn = 0;
    at_done = '0;
    for (int i = 1; i <= 20; i++) begin
      req = (i == 7);
      req_mode = (i == 7) ? 2'b01 : 2'b00;
      tick();
      if (i == 7) checkOutput("t5_reject", obs_a[0], 1);
      if (i == 8) checkOutput("t5_reject_drop", obs_a[0], 0);
      if (obs_a[2] && dn == 0) begin
        dn = i;
        at_done = obs_a;
      end
    end
    req = 1'b0;
    checkOutput("t5_done_at", dn, 12);
    checkOutput("t5_mode_fir", at_done[11:8], 4'b1001);
    checkOutput("t5_idle_after", obs_a, E_IDLE_F);

    // Reset in the middle of FLUSH.
    doReset();
    req = 1'b1; req_mode = 2'b11;
    tick();
    req = 1'b0;
    tick();
    checkOutput("t6_in_flush", obs_a, E_FLUSH);
    rst = 1'b1;
    tick();
    checkOutput("t6_reset_mid", obs_a, E_ZERO);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_a[2]) dn++;
    end
    checkOutput("t6_no_done", dn, 0);
    checkOutput("t6_stay_sir", obs_a, E_ZERO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
